// File: rtl/mem_pkg.sv
// Shared constants for the unified memory port: RV32I load/store funct3
// encodings, base byte-enable patterns, arbiter state codes and requester IDs.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BUSY_I = 3'd1;
  localparam logic [2:0] ST_BUSY_D = 3'd2;
  localparam logic [2:0] ST_DONE_I = 3'd3;
  localparam logic [2:0] ST_DONE_D = 3'd4;
  localparam logic [2:0] ST_ERR_D  = 3'd5;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane formatting for the data port: byte enables, store-data shift,
// bad-access detection and load extraction/extension. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic        bad,
  output logic [31:0] rdata_ext
);

  logic [3:0]  be_base;
  logic [31:0] sh;

  // Size-based byte enables and store data moved onto the addressed lanes.
  always_comb begin
    case (funct3[1:0])
      2'b00:   be_base = BE_B;
      2'b01:   be_base = BE_H;
      default: be_base = BE_W;
    endcase
    be       = be_base << off;
    wdata_sh = wdata << {off, 3'b000};
  end

  // Illegal funct3, narrow-only funct3 on a store, or size misalignment.
  always_comb begin
    bad = 1'b0;
    case (funct3)
      3'b011, 3'b110, 3'b111: bad = 1'b1;
      default: ;
    endcase
    if (we && funct3[2])                     bad = 1'b1;
    if (funct3[1:0] == 2'b01 && off[0])      bad = 1'b1;
    if (funct3[1:0] == 2'b10 && off != 2'b0) bad = 1'b1;
  end

  // Bring the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    sh = rdata >> {off, 3'b000};
    case (funct3)
      F3_LB:   rdata_ext = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   rdata_ext = {{16{sh[15]}}, sh[15:0]};
      F3_LW:   rdata_ext = sh;
      F3_LBU:  rdata_ext = {24'd0, sh[7:0]};
      F3_LHU:  rdata_ext = {16'd0, sh[15:0]};
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Moore outputs from registered state; every memory transaction is bounded
// by TIMEOUT cycles; bad data accesses complete with an error, no memory hit.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic [31:0] I_RDATA,
  output logic        I_ACK,
  output logic        I_ERR,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [2:0]  D_FUNCT3,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic [31:0] D_RDATA,
  output logic        D_ACK,
  output logic        D_ERR,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [3:0]  M_BE,
  output logic [31:0] M_WDATA,
  input  logic [31:0] M_RDATA,
  input  logic        M_ACK
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state;
  logic        last_grant;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic        idle, busy, grant_d;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_bad;

  // In IDLE the aligner looks at the live D request (grant-time formatting);
  // otherwise at the latched operands (load extraction in BUSY_D).
  assign idle    = (state == ST_IDLE);
  assign busy    = (state == ST_BUSY_I) || (state == ST_BUSY_D);
  assign al_f3   = idle ? D_FUNCT3 : f3_q;
  assign al_off  = idle ? D_ADDR[1:0] : addr_q[1:0];
  // D wins when alone or when I was granted last.
  assign grant_d = D_REQ && (!I_REQ || last_grant == REQ_I);

  mem_lane_align u_align (
    .funct3    (al_f3),
    .we        (D_WE),
    .off       (al_off),
    .wdata     (D_WDATA),
    .rdata     (M_RDATA),
    .be        (al_be),
    .wdata_sh  (al_wdata),
    .bad       (al_bad),
    .rdata_ext (al_rdata)
  );

  // Arbiter FSM, timeout counter, request latches and response registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      last_grant <= REQ_I;
      cnt        <= 8'd0;
      addr_q     <= 32'd0;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= 8'd0;
          if (grant_d) begin
            addr_q  <= D_ADDR;
            we_q    <= D_WE;
            f3_q    <= D_FUNCT3;
            be_q    <= al_be;
            wdata_q <= D_WE ? al_wdata : 32'd0;
            if (al_bad) begin
              d_rdata_q <= 32'd0;
              state     <= ST_ERR_D;
            end else begin
              state <= ST_BUSY_D;
            end
          end else if (I_REQ) begin
            addr_q  <= I_ADDR;
            we_q    <= 1'b0;
            f3_q    <= F3_LW;
            be_q    <= BE_W;
            wdata_q <= 32'd0;
            state   <= ST_BUSY_I;
          end
        end
        ST_BUSY_I: begin
          if (M_ACK) begin
            i_rdata_q <= M_RDATA;
            err_q     <= 1'b0;
            state     <= ST_DONE_I;
          end else if (cnt == CNT_LAST) begin
            i_rdata_q <= 32'd0;
            err_q     <= 1'b1;
            state     <= ST_DONE_I;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_BUSY_D: begin
          if (M_ACK) begin
            d_rdata_q <= al_rdata;
            err_q     <= 1'b0;
            state     <= ST_DONE_D;
          end else if (cnt == CNT_LAST) begin
            d_rdata_q <= 32'd0;
            err_q     <= 1'b1;
            state     <= ST_DONE_D;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE_I: begin
          last_grant <= REQ_I;
          state      <= ST_IDLE;
        end
        ST_DONE_D, ST_ERR_D: begin
          last_grant <= REQ_D;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode; memory-side fields are zero outside BUSY.
  assign M_REQ   = busy;
  assign M_WE    = (state == ST_BUSY_D) && we_q;
  assign M_ADDR  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign M_BE    = busy ? be_q : 4'd0;
  assign M_WDATA = busy ? wdata_q : 32'd0;
  assign I_ACK   = (state == ST_DONE_I);
  assign I_ERR   = (state == ST_DONE_I) && err_q;
  assign D_ACK   = (state == ST_DONE_D) || (state == ST_ERR_D);
  assign D_ERR   = (state == ST_ERR_D) || ((state == ST_DONE_D) && err_q);
  assign I_RDATA = i_rdata_q;
  assign D_RDATA = d_rdata_q;

endmodule
